multicycle_ctrl: RTL and testbench

//  Multicycle sequencer for the MIPS subset (R-type ADD/SUB/AND/OR/XOR/NOR, ADDI, LW, SW).

---
 rtl/multicycle_ctrl_pkg.sv | 49 ++++
 rtl/multicycle_ctrl_if.sv | 18 +
 rtl/multicycle_ctrl_mem_wait_timer.sv | 27 ++
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS-subset sequencer: opcodes, functs,
// ALU codes, operand-select encodings, trap codes and the FSM state type.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [5:0] ALU_ADD = FN_ADD;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] DATA_WORD = 2'b11;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_OPCODE  = 2'b01;
    localparam logic [1:0] TRAP_FUNCT   = 2'b10;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_IDLE,
        S_TRAP
    } state_t;

    function automatic logic legal_opcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic legal_funct(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_XOR) || (fn == FN_NOR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port between the sequencer (master) and memory (slave).
interface multicycle_ctrl_if;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic [1:0] data_size;
    logic       mem_ready;

    modport master (
        output mem_read, mem_write, iord, data_size,
        input  mem_ready
    );

    modport slave (
        input  mem_read, mem_write, iord, data_size,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts cycles a memory request waits for ready; expired flags the final
// permitted cycle so the caller can still honour a ready arriving on it.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == W'(LIMIT - 1));
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready stalls,
// halt at instruction boundaries and sticky traps.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             halt_req,
    multicycle_ctrl_if.master bus,
    output logic             pc_write,
    output logic             ir_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [5:0]       alu_func,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_code
);
    state_t     state, state_nxt;
    logic [1:0] trap_code_nxt;
    logic       waiting, expired, retire;
    logic       is_r, is_lw, is_sw;

    assign is_r  = (opcode == OP_RTYPE);
    assign is_lw = (opcode == OP_LW);
    assign is_sw = (opcode == OP_SW);

    assign waiting = (state == S_FETCH) || (state == S_MEM);
    assign retire  = (state == S_WB) || ((state == S_MEM) && is_sw && bus.mem_ready);

    mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!waiting || bus.mem_ready),
        .enable  (waiting && !bus.mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            trap_code <= TRAP_NONE;
            retired   <= '0;
        end else begin
            state     <= state_nxt;
            trap_code <= trap_code_nxt;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        trap_code_nxt = trap_code;
        unique case (state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (expired) begin
                    state_nxt     = S_TRAP;
                    trap_code_nxt = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (!legal_opcode(opcode)) begin
                    state_nxt     = S_TRAP;
                    trap_code_nxt = TRAP_OPCODE;
                end else if (is_r && !legal_funct(funct)) begin
                    state_nxt     = S_TRAP;
                    trap_code_nxt = TRAP_FUNCT;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC:  state_nxt = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (is_sw) state_nxt = halt_req ? S_IDLE : S_FETCH;
                    else       state_nxt = S_WB;
                end else if (expired) begin
                    state_nxt     = S_TRAP;
                    trap_code_nxt = TRAP_TIMEOUT;
                end
            end
            S_WB:    state_nxt = halt_req ? S_IDLE : S_FETCH;
            S_IDLE:  if (!halt_req) state_nxt = S_FETCH;
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Strobes are also forced idle while rst_n is low so an aborted request
    // drops immediately rather than showing FETCH's read during reset.
    always_comb begin
        pc_write       = 1'b0;
        ir_write       = 1'b0;
        bus.iord       = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = SRCB_REG;
        alu_func       = ALU_ADD;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        reg_write      = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.data_size  = DATA_WORD;
        instr_done     = 1'b0;
        if (rst_n) begin
            instr_done = retire;
            unique case (state)
                S_FETCH: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = SRCB_FOUR;
                    end
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    if (is_r) begin
                        alu_src_b = SRCB_REG;
                        alu_func  = funct;
                    end else begin
                        alu_src_b = SRCB_IMM;
                    end
                end
                S_MEM: begin
                    bus.iord      = 1'b1;
                    bus.mem_read  = is_lw;
                    bus.mem_write = is_sw;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = is_r;
                    mem_to_reg = is_lw;
                end
                default: ;
            endcase
        end
    end

    assign halted = (state == S_IDLE);
    assign trap   = (state == S_TRAP);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-computed cycle expectations.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        halt_req = 1'b0;
    logic        pc_write, ir_write, alu_src_a, reg_dst, mem_to_reg, reg_write;
    logic [1:0]  alu_src_b, trap_code;
    logic [5:0]  alu_func;
    logic        instr_done, halted, trap;
    logic [31:0] retired;

    int tests = 0;
    int fails = 0;

    logic [40:1] rw_log, mw_log, mr_log, iord_log, mtr_log, rd_log, pcw_log, irw_log;
    logic [5:0]  fn_log [1:40];
    logic [1:0]  sb_log [1:40];
    int          done_at;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .halt_req   (halt_req),
        .bus        (bus),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_func   (alu_func),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .retired    (retired),
        .halted     (halted),
        .trap       (trap),
        .trap_code  (trap_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction; f_rdy/m_rdy are the 1-based cycles carrying mem_ready.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int f_rdy, input int m_rdy, input logic hold);
        done_at = 0;
        rw_log = '0; mw_log = '0; mr_log = '0; iord_log = '0;
        mtr_log = '0; rd_log = '0; pcw_log = '0; irw_log = '0;
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            opcode   = op;
            funct    = fn;
            halt_req = hold;
            bus.mem_ready = (c == f_rdy) || (c == m_rdy);
            #1;
            rw_log[c]   = reg_write;
            mw_log[c]   = bus.mem_write;
            mr_log[c]   = bus.mem_read;
            iord_log[c] = bus.iord;
            mtr_log[c]  = mem_to_reg;
            rd_log[c]   = reg_dst;
            pcw_log[c]  = pc_write;
            irw_log[c]  = ir_write;
            fn_log[c]   = alu_func;
            sb_log[c]   = alu_src_b;
            if (instr_done) done_at = c;
            tick();
        end
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_retired", retired, 0);
        check("rst_trap", {trap, trap_code}, 0);
        check("rst_alu_func", alu_func, 6'b100000);
        check("rst_data_size", bus.data_size, 2'b11);
        check("rst_alu_src_b", alu_src_b, 0);
        rst_n = 1'b1;

        // ADD: F D E W
        run_instr(6'b000000, 6'b100000, 1, 0, 1'b0);
        check("add_done_cycle", done_at, 4);
        check("add_fetch_strobes", {irw_log[1], pcw_log[1], sb_log[1], fn_log[1]}, {1'b1, 1'b1, 2'b01, 6'b100000});
        check("add_exec_func", fn_log[3], 6'b100000);
        check("add_reg_write", rw_log, 40'h8);
        check("add_reg_dst", rd_log[4], 1);
        check("add_retired", retired, 1);

        run_instr(6'b000000, 6'b100111, 1, 0, 1'b0);
        check("nor_exec_func", fn_log[3], 6'b100111);
        check("nor_retired", retired, 2);

        // LW with 3 wait cycles in FETCH and MEM: 4 + 1 + 1 + 4 + 1
        run_instr(6'b100011, 6'b000000, 4, 10, 1'b0);
        check("lw_done_cycle", done_at, 11);
        check("lw_mem_to_reg", mtr_log, 40'h400);
        check("lw_reg_write", rw_log, 40'h400);
        check("lw_mem_rd_iord", {mr_log[10], iord_log[10], mr_log[5]}, 3'b110);
        check("lw_exec_srcb", sb_log[6], 2'b10);
        check("lw_pc_write", pcw_log, 40'h8);
        check("lw_retired", retired, 3);

        run_instr(6'b101011, 6'b000000, 1, 4, 1'b0);
        check("sw_done_cycle", done_at, 4);
        check("sw_mem_write", {mw_log[4], iord_log[4], mr_log[4]}, 3'b110);
        check("sw_no_reg_write", rw_log, 0);
        check("sw_retired", retired, 4);

        // ADDI with halt request
        run_instr(6'b001000, 6'b000000, 1, 0, 1'b1);
        check("addi_done_cycle", done_at, 4);
        check("addi_wb", {rw_log[4], rd_log[4], mtr_log[4]}, 3'b100);
        check("addi_halted", {halted, bus.mem_read}, 2'b10);
        tick();
        check("idle_hold", {halted, bus.mem_read, retired}, {1'b1, 1'b0, 32'd5});
        halt_req = 1'b0;
        tick();
        check("idle_resume", {halted, bus.mem_read}, 2'b01);

        // illegal opcode traps two cycles after fetch
        opcode = 6'b000100;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("ill_op_decode", trap, 0);
        tick();
        check("ill_op_trap", {trap, trap_code, halted}, 4'b1010);
        bus.mem_ready = 1'b1;
        repeat (3) tick();
        check("trap_strobes", {bus.mem_read, bus.mem_write, reg_write, pc_write, ir_write, trap}, 6'b000001);
        bus.mem_ready = 1'b0;

        rst_n = 1'b0;
        #1;
        check("trap_reset", {trap, trap_code, retired}, 0);
        rst_n = 1'b1;

        // illegal R funct
        opcode = 6'b000000;
        funct  = 6'b101010;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        check("ill_fn_trap", {trap, trap_code}, 3'b110);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        // FETCH timeout after 4 cycles without ready
        repeat (3) tick();
        check("fetch_to_cycle4", {trap, bus.mem_read}, 2'b01);
        tick();
        check("fetch_timeout", {trap, trap_code}, 3'b111);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        // ready on the final count cycle wins
        opcode = 6'b100011;
        repeat (3) tick();
        bus.mem_ready = 1'b1;
        #1;
        check("fetch_rdy_last", ir_write, 1);
        tick();
        bus.mem_ready = 1'b0;
        check("fetch_rdy_last_notrap", {trap, bus.mem_read}, 2'b00);
        repeat (2) tick();
        check("lw_in_mem", {bus.mem_read, bus.iord}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("mid_mem_reset",
              {bus.mem_read, bus.iord, bus.mem_write, reg_write, alu_func, alu_src_b, bus.data_size, trap, instr_done},
              {4'b0000, 6'b100000, 2'b00, 2'b11, 2'b00});
        check("mid_mem_retired", retired, 0);
        tick();
        rst_n = 1'b1;

        // MEM timeout on LW: F D E then 4 MEM cycles, no write, no retire
        run_instr(6'b100011, 6'b000000, 1, 0, 1'b0);
        check("mem_to_no_retire", done_at, 0);
        check("mem_to_no_write", rw_log, 0);
        check("mem_to_read_window", {mr_log[7], mr_log[8]}, 2'b10);
        check("mem_to_trap", {trap, trap_code, retired}, {3'b111, 32'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
